// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - two-requester round-robin arbiter feeding one transceiver
//
// Purpose:
//   Takes one request word at a time from two requesters and runs a single
//   transceiver transfer for it. The FSM steps through IDLE, SAMPLE, START,
//   WAIT and DONE. Round-robin priority goes to the requester that was not
//   served last. Requester 0 holds priority after reset.
//
// Optional feature (macro TX_ARB_TIMEOUT_EN):
//   defined   - a cycle counter runs in START/WAIT. After TIMEOUT cycles
//               without txDone, timeout pulses for one cycle and the transfer
//               is abandoned with no done pulse.
//   undefined - no counter is built, timeout is tied low, and START/WAIT
//               wait indefinitely.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   req0/req1          level requests, held until the matching gnt
//   din0/din1          request words, valid while the matching req is high
//   gnt0/gnt1          one-cycle pulse: request word captured into dataOut
//   done0/done1        one-cycle pulse: that requester's transfer completed
//   txBusy, txDone     transceiver busy level and completion pulse
//   sample, startTx    transceiver load strobe and start request
//   dataOut            registered word presented to the transceiver
//   busy               high in every state except IDLE
//   timeout            one-cycle abort pulse (TX_ARB_TIMEOUT_EN builds only)
module tx_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    input  logic                  txBusy,
    input  logic                  txDone,
    output logic                  sample,
    output logic                  startTx,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  busy,
    output logic                  timeout
);

    typedef enum logic [2:0] {IDLE, SAMPLE, START, WAIT, DONE} state_t;

    state_t state, state_next;
    logic   prio;     // requester that wins when both request
    logic   served;   // requester owning the current transfer
    logic   gnt_q;
    logic   pick;
    logic   any_req;
    logic   abort;    // transfer abandoned by the timeout counter

    assign any_req = req0 | req1;
    // A lone requester always wins; priority matters only under contention.
    assign pick    = (req0 && req1) ? prio : req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = SAMPLE;
            SAMPLE:  state_next = START;
            // txDone takes precedence over txBusy so an early finish is not missed.
            START:   if (txDone) state_next = DONE;
                     else if (txBusy) state_next = WAIT;
            WAIT:    if (txDone) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataOut <= '0;
            gnt_q   <= 1'b0;
            served  <= 1'b0;
            prio    <= 1'b0;
        end else begin
            gnt_q <= (state == IDLE) && any_req;
            if ((state == IDLE) && any_req) begin
                served  <= pick;
                dataOut <= pick ? din1 : din0;
            end
            // Completed or abandoned, the served requester drops to low priority.
            if ((state == DONE) || abort) prio <= ~served;
        end
    end

    assign gnt0    = gnt_q & ~served;
    assign gnt1    = gnt_q & served;
    assign done0   = (state == DONE) & ~served;
    assign done1   = (state == DONE) & served;
    assign sample  = (state == SAMPLE);
    assign startTx = (state == START);
    assign busy    = (state != IDLE);

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             timeout_q;
    logic             in_xfer;

    assign in_xfer = (state == START) || (state == WAIT);
    // Expires on the last of TIMEOUT cycles in START/WAIT; a txDone on that cycle still wins.
    assign abort   = in_xfer && !txDone && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= abort;
            cnt       <= (in_xfer && !abort) ? cnt + CNT_W'(1) : '0;
        end
    end

    assign timeout = timeout_q;
`else
    // TIMEOUT has no effect in this build; it stays on the parameter list so both builds share one interface.
    logic unused_timeout_param;
    assign unused_timeout_param = TIMEOUT[0];
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - scoreboard bench for tx_arbiter
module tb_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] din0, din1;
    logic        gnt0, gnt1, done0, done1;
    logic        txBusy, txDone;
    logic        sample, startTx;
    logic [31:0] dataOut;
    logic        busy, timeout;

    always #5 clk = ~clk;

    tx_arbiter #(.DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .din0(din0), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .txBusy(txBusy), .txDone(txDone),
        .sample(sample), .startTx(startTx),
        .dataOut(dataOut), .busy(busy), .timeout(timeout)
    );

    // kind: 0 = grant, 1 = done, 2 = timeout
    typedef struct {
        int          kind;
        int          id;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          sample_cnt   = 0;
    int          cyc          = 0;
    int          start_cyc    = 0;
    int          tx_mode      = 0;  // 0 normal, 1 early done, 2 never completes
    int          tx_cnt       = 0;
    bit          tx_on        = 1'b0;
    bit          prev_txdone  = 1'b0;
    bit          prev_start   = 1'b0;
    logic [31:0] held         = '0;
    logic [31:0] d0[2];
    logic [31:0] d1[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int id, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_ev(input int kind, input int id);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", 32'(kind * 16 + id), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_id", 32'(id), 32'(e.id));
            if (kind != 2) check("event_data", dataOut, e.data);
        end
    endtask

    always @(posedge clk) cyc++;

    // Transceiver model: busy 2 cycles after startTx, done 10 cycles after that.
    initial begin
        txBusy = 1'b0;
        txDone = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            txDone = 1'b0;
            if (reset || !busy) begin
                tx_on  = 1'b0;
                txBusy = 1'b0;
            end else if (!tx_on) begin
                if (startTx) begin
                    tx_on  = 1'b1;
                    tx_cnt = 0;
                end
            end else begin
                tx_cnt++;
                if (tx_mode != 1 && tx_cnt == 2) txBusy = 1'b1;
                if (tx_mode == 0 && tx_cnt == 12) begin
                    txBusy = 1'b0;
                    txDone = 1'b1;
                    tx_on  = 1'b0;
                end
                if (tx_mode == 1 && tx_cnt == 1) begin
                    txDone = 1'b1;
                    tx_on  = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every grant/done/timeout strobe.
    always @(negedge clk) begin
        if (!reset) begin
            if (gnt0)    pop_ev(0, 0);
            if (gnt1)    pop_ev(0, 1);
            if (done0)   pop_ev(1, 0);
            if (done1)   pop_ev(1, 1);
            if (timeout) pop_ev(2, 0);
            if (gnt0 | gnt1 | done0 | done1 | timeout)
                check("strobe_exclusive",
                      32'(($countones({gnt0, gnt1, done0, done1, timeout}) <= 1) ? 1 : 0), 32'd1);
            if (done0 | done1) begin
                check("done_startTx_low", 32'(startTx), 32'd0);
                check("done_after_txdone", 32'(prev_txdone), 32'd1);
            end
            if (gnt0 | gnt1) held = dataOut;
            else if (busy) check("dataout_stable", dataOut, held);
            if (sample) sample_cnt++;
            if (startTx && !prev_start) start_cyc = cyc;
`ifdef TX_ARB_TIMEOUT_EN
            if (timeout) check("timeout_latency", 32'(cyc - start_cyc), 32'd8);
`endif
            prev_txdone = txDone;
            prev_start  = startTx;
        end
    end

    // Drives requesters until n_ev done/timeout events; req0 may start delay0 cycles late.
    task automatic run_reqs(input int n0, input int n1, input int delay0, input int n_ev, input int budget);
        int i0 = 0;
        int i1 = 0;
        int ev = 0;
        din0 = d0[0];
        din1 = d1[0];
        req1 = (n1 > 0);
        if (delay0 == 0) req0 = (n0 > 0);
        for (int c = 0; c < budget && ev < n_ev; c++) begin
            @(negedge clk);
            if (delay0 > 0 && c == delay0 - 1 && n0 > 0) req0 = 1'b1;
            if (gnt0) begin
                i0++;
                if (i0 < n0) din0 = d0[i0];
                else req0 = 1'b0;
            end
            if (gnt1) begin
                i1++;
                if (i1 < n1) din1 = d1[i1];
                else req1 = 1'b0;
            end
            if (done0 | done1 | timeout) ev++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("xfer_events", 32'(ev), 32'(n_ev));
        @(negedge clk);
        check("idle_after_xfer", 32'(busy), 32'd0);
    endtask

    initial begin
        int c;
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        din0  = '0;
        din1  = '0;
        repeat (2) @(negedge clk);
        check("reset_strobes", 32'({gnt0, gnt1, done0, done1, sample, startTx, busy, timeout}), 32'd0);
        check("reset_dataout", dataOut, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'(busy), 32'd0);

        // Contention from reset: grant order 0,1,0,1.
        d0[0] = 32'h1111_0000; d0[1] = 32'h1111_0001;
        d1[0] = 32'h2222_0000; d1[1] = 32'h2222_0001;
        push_ev(0, 0, d0[0]); push_ev(1, 0, d0[0]);
        push_ev(0, 1, d1[0]); push_ev(1, 1, d1[0]);
        push_ev(0, 0, d0[1]); push_ev(1, 0, d0[1]);
        push_ev(0, 1, d1[1]); push_ev(1, 1, d1[1]);
        sample_cnt = 0;
        tx_mode    = 0;
        run_reqs(2, 2, 0, 4, 200);
        check("contention_samples", 32'(sample_cnt), 32'd4);

        // Single request.
        d0[0] = 32'hA5A5_1234;
        push_ev(0, 0, d0[0]); push_ev(1, 0, d0[0]);
        sample_cnt = 0;
        run_reqs(1, 0, 0, 1, 100);
        check("single_samples", 32'(sample_cnt), 32'd1);

        // Early done while txBusy is still low.
        d1[0] = 32'h0BAD_F00D;
        push_ev(0, 1, d1[0]); push_ev(1, 1, d1[0]);
        tx_mode = 1;
        run_reqs(0, 1, 0, 1, 50);
        tx_mode = 0;

        // A request withdrawn before its grant is ignored.
        d0[0] = 32'h3333_4444;
        push_ev(0, 0, d0[0]); push_ev(1, 0, d0[0]);
        fork
            run_reqs(1, 0, 0, 1, 100);
            begin
                repeat (3) @(negedge clk);
                req1 = 1'b1;
                @(negedge clk);
                req1 = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("withdrawn_req_ignored", 32'(exp_q.size()), 32'd0);

`ifdef TX_ARB_TIMEOUT_EN
        // Transceiver never finishes: timeout, then a normal transfer.
        d0[0] = 32'h7777_0001;
        push_ev(0, 0, d0[0]); push_ev(2, 0, 32'd0);
        tx_mode = 2;
        run_reqs(1, 0, 0, 1, 60);
        tx_mode = 0;
        d1[0] = 32'h7777_0002;
        push_ev(0, 1, d1[0]); push_ev(1, 1, d1[0]);
        run_reqs(0, 1, 0, 1, 100);
        tx_mode = 0;
`else
        tx_mode = 2;
`endif

        // Reset while in WAIT: no done pulse, outputs clear at once.
        push_ev(0, 0, 32'h5555_6666);
        din0 = 32'h5555_6666;
        req0 = 1'b1;
        for (c = 0; c < 20 && !gnt0; c++) @(negedge clk);
        req0 = 1'b0;
        check("wait_test_grant", 32'(gnt0), 32'd1);
        for (c = 0; c < 20 && !txBusy; c++) @(negedge clk);
        @(negedge clk);
        check("in_wait", 32'({busy, startTx, txBusy}), 32'b101);
`ifndef TX_ARB_TIMEOUT_EN
        c = 0;
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            if (!(busy && !startTx && !sample && !timeout)) c++;
        end
        check("wait_hold_110", 32'(c), 32'd0);
`endif
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_strobes", 32'({gnt0, gnt1, done0, done1, sample, startTx, busy, timeout}), 32'd0);
        check("async_reset_dataout", dataOut, 32'd0);
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        tx_mode = 0;
        check("no_done_after_reset", 32'(exp_q.size()), 32'd0);

        // After reset: req1 raised first, req0 one cycle later.
        d1[0] = 32'h1111_AAAA;
        d0[0] = 32'h2222_BBBB;
        push_ev(0, 1, d1[0]); push_ev(1, 1, d1[0]);
        push_ev(0, 0, d0[0]); push_ev(1, 0, d0[0]);
        run_reqs(1, 1, 1, 2, 200);

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
